dh_modexp_sequencer: RTL and testbench
======================================

# dh_modexp_sequencer

Sequential modular-exponentiation controller for the Diffie-Hellman key path. It computes key = base^exp mod p using one shared bit-serial modular multiplier, sequenced by a square-and-multiply FSM. It sits between the key-agreement inputs and the encryption round: its `key` output feeds the round's `exp` operand, and its one-cycle `done` pulse is the round's `done_c_i` enable.

## Interface
- `W`, 32, width of modulus, base and key
- `EW`, 32, width of exponent
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `base`  in  W  generator/public value; any value, including base ≥ p
- `exp_in`  in  EW  exponent (private key)
- `p`  in  W  modulus
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle
- `done`  out  1  one-cycle pulse, key/err valid
- `key`  out  W  result, held until the next completion
- `err`  out  1  set with done when p == 0, else cleared with done

## Operation
- Reset: state IDLE; busy=0, done=0, key=0, err=0; all internal registers 0.
- IDLE: on start=1, latch base, exp_in, p.
  - If p==0, go to DONE with key=0, err=1.
  - Otherwise, go to REDUCE with bit counter = W-1 and acc=0.
  - Result register r = (p==1) ? 0 : 1.
- REDUCE (W cycles, MSB first): acc = 2·acc + base[i]; if acc ≥ p, acc -= p. At the end, b = acc (base mod p). Go to SQR at exponent bit EW-1.
- SQR (W cycles): interleaved modmul computing r·r mod p, scanning multiplier bits MSB first.
  - Each cycle: t = 2·t mod p (one conditional subtract), then if bit set, t = t + r mod p (one conditional subtract).
  - Datapath intermediates are W+1 bits; all operands are < p.
  - On completion: r = t. If the current exponent bit = 1, go to MUL. Otherwise, advance to the next bit or go to DONE after bit 0.
- MUL (W cycles): same engine computing r·b mod p. Then advance to the next bit, or go to DONE after bit 0.
- DONE (1 cycle): done=1, key=r (or 0 on error), err updated. Next state is IDLE.
- All EW exponent bits are processed; leading zeros are not skipped. This gives data-dependent latency only through popcount.
- start while busy: ignored, with no queuing.
- Input changes after acceptance: no effect, because operands are latched.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A partial result is never presented.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- p ≠ 0: done is high in cycle N = 1 + W + W·(EW + popcount(exp_in)). busy is high in cycles 1..N.
- p == 0: done is high in cycle 1; busy is high in cycle 1 only.
- key and err change only on the edge that raises done. They remain stable until the next done or reset.
- A new start is accepted at the earliest in cycle N+1 (IDLE again).
- The downstream round samples key in the done cycle. key is already registered there, so no extra hold is required.
- The modmul engine uses one shared adder/subtractor path. Exactly one modular step is performed per cycle.

## Test plan
- W=EW=32, base=5, exp=6, p=23, start pulse -> done at cycle 1+32+32·34=1121, key=8, err=0, busy high cycles 1..1121.
- base=100, exp=1, p=7 -> key=2 (base ≥ p reduced correctly), done at cycle 1+32+32·33=1089.
- base=2, exp=0xFFFFFFFF, p=0xFFFFFFFB -> key=32 (Fermat check), done at cycle 2081. Also exp=0, p=23 -> key=1. Also p=1 -> key=0.
- p=0, base=9, exp=3 -> done in cycle 1, key=0, err=1. A following valid request then clears err.
- Second start raised while busy, with different operands -> ignored; first result is unchanged and only one done pulse occurs.
- rst asserted at cycle 500 of a run -> busy/done/key/err=0 immediately. After release, a fresh request completes with the correct value and nominal latency.

Source files
------------

// File: rtl/dh_modexp_sequencer.sv
// Square-and-multiply modular exponentiation (key = base^exp mod p) built around
// one bit-serial interleaved modular multiplier; one modular step per cycle.
module dh_modexp_sequencer #(
    parameter int W  = 32,
    parameter int EW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp_in,
    input  logic [W-1:0]  p,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  key,
    output logic          err
);

    localparam int CW  = (W  > 1) ? $clog2(W)  : 1;
    localparam int EBW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [EBW-1:0]  ebit;
    logic [W-1:0]    base_q, p_q, r, b, t;
    logic [EW-1:0]   exp_q;

    logic            mbit, last;
    logic [W-1:0]    addend, d1, t_nx;
    logic [W:0]      dbl, sum, pw;

    // Shared engine step: t = 2t mod p, then optionally t = t + addend mod p.
    // REDUCE reuses it with addend 1 so acc = 2acc + base[i] mod p.
    always_comb begin
        mbit   = 1'b0;
        addend = r;
        case (state)
            REDUCE: begin mbit = base_q[cnt]; addend = W'(1); end
            SQR:    begin mbit = r[cnt];      addend = r;     end
            MUL:    begin mbit = b[cnt];      addend = r;     end
            default: ;
        endcase
        pw   = {1'b0, p_q};
        dbl  = {t, 1'b0};
        d1   = W'((dbl >= pw) ? dbl - pw : dbl);
        sum  = {1'b0, d1} + {1'b0, addend};
        t_nx = mbit ? W'((sum >= pw) ? sum - pw : sum) : d1;
    end

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:   if (start) state_nx = (p == '0) ? DONE : REDUCE;
            REDUCE: if (last) state_nx = SQR;
            SQR:    if (last) begin
                        if (exp_q[ebit])      state_nx = MUL;
                        else if (ebit == '0)  state_nx = DONE;
                        else                  state_nx = SQR;
                    end
            MUL:    if (last) state_nx = (ebit == '0) ? DONE : SQR;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            ebit   <= '0;
            base_q <= '0;
            exp_q  <= '0;
            p_q    <= '0;
            r      <= '0;
            b      <= '0;
            t      <= '0;
            key    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q <= base;
                    exp_q  <= exp_in;
                    p_q    <= p;
                    cnt    <= CW'(W-1);
                    ebit   <= EBW'(EW-1);
                    t      <= '0;
                    r      <= (p == W'(1)) ? '0 : W'(1);
                    if (p == '0) begin
                        key <= '0;
                        err <= 1'b1;
                    end
                end
                REDUCE: begin
                    t   <= t_nx;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        b   <= t_nx;
                        t   <= '0;
                        cnt <= CW'(W-1);
                    end
                end
                SQR, MUL: begin
                    t   <= t_nx;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        r   <= t_nx;
                        t   <= '0;
                        cnt <= CW'(W-1);
                        // Going back to SQR means this exponent bit is finished.
                        if (state_nx == SQR) ebit <= ebit - 1'b1;
                        if (state_nx == DONE) begin
                            key <= t_nx;
                            err <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_modexp_sequencer.sv
// Randomized + directed check of dh_modexp_sequencer against a right-to-left
// binary exponentiation model, including latency, busy window and reset abort.
module tb_dh_modexp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base, exp_in, p;
    logic        busy, done, err;
    logic [31:0] key;

    int n_tests = 0;
    int n_fail  = 0;

    dh_modexp_sequencer #(.W(32), .EW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp_in(exp_in),
        .p(p), .busy(busy), .done(done), .key(key), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] bs, input logic [31:0] e,
                                          input logic [31:0] m);
        longint unsigned acc, bb, mm;
        logic [31:0] ee;
        if (m == 0) return 32'd0;
        mm  = 64'(m);
        acc = 64'd1 % mm;
        bb  = 64'(bs) % mm;
        ee  = e;
        while (ee != 0) begin
            if (ee[0]) acc = (acc * bb) % mm;
            bb = (bb * bb) % mm;
            ee = ee >> 1;
        end
        return 32'(acc);
    endfunction

    // inj: cycle in which a second start is raised; rcyc: cycle in which rst is pulled (0 = none)
    task automatic run_op(input logic [31:0] b_i, input logic [31:0] e_i, input logic [31:0] p_i,
                          input int inj, input int rcyc, input string tag);
        logic [31:0] ek, prev_key;
        logic        eerr;
        int          n, cyc, extra;
        bit          got, busy_bad, key_bad;
        ek   = model(b_i, e_i, p_i);
        eerr = (p_i == 0);
        n    = (p_i == 0) ? 1 : 1 + 32 + 32 * (32 + $countones(e_i));
        @(negedge clk);
        base = b_i; exp_in = e_i; p = p_i; start = 1'b1;
        prev_key = key;
        @(posedge clk); #1;
        start = 1'b0;
        base = $urandom; exp_in = $urandom; p = $urandom;
        cyc = 1; got = 0; busy_bad = 0; key_bad = 0;
        while (!got && cyc <= n + 10) begin
            if (cyc == rcyc) begin
                rst = 1'b0;
                #1;
                chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
                chk({tag, "_rst_done"}, 64'(done), 64'd0);
                chk({tag, "_rst_key"},  64'(key),  64'd0);
                chk({tag, "_rst_err"},  64'(err),  64'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            start = (cyc == inj);
            if (cyc == inj) begin
                base = $urandom; exp_in = $urandom; p = $urandom | 32'h1;
            end
            if (!busy) busy_bad = 1;
            if (done) got = 1;
            else begin
                if (key !== prev_key) key_bad = 1;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(n));
        chk({tag, "_key"}, 64'(key), 64'(ek));
        chk({tag, "_err"}, 64'(err), 64'(eerr));
        chk({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
        chk({tag, "_key_stable"}, 64'(key_bad), 64'd0);
        extra = 0;
        repeat ((inj > 0) ? 40 : 3) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        chk({tag, "_post_idle"}, 64'(extra), 64'd0);
        chk({tag, "_key_hold"}, 64'(key), 64'(ek));
    endtask

    initial begin
        logic [31:0] rb, re, rp;
        rst = 1'b0; start = 1'b0; base = '0; exp_in = '0; p = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_key",  64'(key),  64'd0);
        chk("reset_err",  64'(err),  64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(32'd5,   32'd6,          32'd23,         0, 0, "basic");
        run_op(32'd100, 32'd1,          32'd7,          0, 0, "base_ge_p");
        run_op(32'd2,   32'hFFFF_FFFF,  32'hFFFF_FFFB,  0, 0, "fermat");
        run_op($urandom, 32'd0,         32'd23,         0, 0, "exp_zero");
        run_op($urandom, $urandom,      32'd1,          0, 0, "p_one");
        run_op(32'd9,   32'd3,          32'd0,          0, 0, "p_zero");
        run_op(32'd7,   32'd5,          32'd101,        0, 0, "err_clear");
        run_op(32'd3,   32'h0001_2345,  32'd1000003,  200, 0, "start_busy");
        run_op(32'd11,  32'hDEAD_BEEF,  32'hFFFF_FFF1,  0, 500, "abort");
        run_op(32'd5,   32'd6,          32'd23,         0, 0, "after_abort");

        for (int i = 0; i < 8; i++) begin
            rb = $urandom;
            re = $urandom;
            rp = $urandom;
            if (i == 0) rp = 32'hFFFF_FFFF;
            if (i == 1) rp = 32'h8000_0000;
            if (i == 2) rb = 32'hFFFF_FFFF;
            run_op(rb, re, rp, 0, 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
